// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter shared definitions
// FSM state encoding and index helpers
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_ACK,
    WAIT_DONE
  } arb_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int wrap_inc(
    input int i,
    input int n
  );
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter requester bus
// per-requester valid/ready byte handshake
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;

  modport master (
    output req_valid,
    output req_data,
    output req_last,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  req_last,
    output req_ready
  );

endinterface

// File: rtl/uart_tx_arbiter_picker.sv
// uart_rr_picker: round-robin first-valid search
// scans upward from ptr, wrapping at N
module uart_rr_picker
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N = 4,
  parameter int W = idx_w(N)
) (
  input  logic [N-1:0] valid,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  // descending scan so the nearest candidate to ptr wins
  always_comb begin
    int c;
    c     = 0;
    found = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      if (valid[c[W-1:0]]) begin
        found = 1'b1;
        idx   = c[W-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter
// round-robin per packet, lock held until last byte
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int  NUM_REQ      = 4,
  parameter int  ACK_TIMEOUT  = 4,
  parameter int  LOCK_TIMEOUT = 120000,
  localparam int W            = idx_w(NUM_REQ)
) (
  input  logic         clk,
  input  logic         reset,
  uart_tx_arbiter_if.slave req,
  output logic [7:0]   tx_data,
  output logic         tx_start,
  input  logic         tx_busy,
  output logic [W-1:0] grant_id,
  output logic         locked,
  output logic         err_ack_timeout,
  output logic         err_lock_revoked
);

  localparam int AW = $clog2(ACK_TIMEOUT + 1);
  localparam int LW = $clog2(LOCK_TIMEOUT + 1);

  arb_state_e    state;
  logic [W-1:0]  rr_ptr;
  logic          last_q;
  logic [AW-1:0] ack_cnt;
  logic [LW-1:0] lock_cnt;

  logic          pick_found;
  logic [W-1:0]  pick_idx;
  logic [W-1:0]  sel;
  logic          accept;
  logic [7:0]    sel_data;
  logic          sel_last;
  logic [W-1:0]  next_ptr;

  uart_rr_picker #(
    .N (NUM_REQ),
    .W (W)
  ) u_pick (
    .valid (req.req_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign next_ptr = W'(wrap_inc(int'(grant_id), NUM_REQ));

  // pick the candidate and decide if it is taken this cycle
  always_comb begin
    sel    = locked ? grant_id : pick_idx;
    accept = 1'b0;
    if (!reset && state == IDLE && !tx_busy)
      accept = locked ? req.req_valid[grant_id]
                      : pick_found;
    sel_data = req.req_data[{sel, 3'b000} +: 8];
    sel_last = req.req_last[sel];
  end

  assign req.req_ready = accept ? (NUM_REQ'(1) << sel)
                                : '0;

  // arbitration FSM; all outputs registered except ready
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      tx_data          <= '0;
      tx_start         <= 1'b0;
      grant_id         <= '0;
      locked           <= 1'b0;
      last_q           <= 1'b0;
      rr_ptr           <= '0;
      ack_cnt          <= '0;
      lock_cnt         <= '0;
      err_ack_timeout  <= 1'b0;
      err_lock_revoked <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            tx_data  <= sel_data;
            last_q   <= sel_last;
            grant_id <= sel;
            tx_start <= 1'b1;
            lock_cnt <= '0;
            state    <= START;
          end else if (locked &&
                       !req.req_valid[grant_id]) begin
            if (lock_cnt == LW'(LOCK_TIMEOUT - 1)) begin
              locked           <= 1'b0;
              rr_ptr           <= next_ptr;
              err_lock_revoked <= 1'b1;
              lock_cnt         <= '0;
            end else begin
              lock_cnt <= lock_cnt + LW'(1);
            end
          end
        end
        START: begin
          ack_cnt <= '0;
          state   <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (tx_busy) begin
            ack_cnt <= '0;
            state   <= WAIT_DONE;
          end else if (ack_cnt == AW'(ACK_TIMEOUT - 1)) begin
            err_ack_timeout <= 1'b1;
            ack_cnt         <= '0;
            state           <= WAIT_DONE;
          end else begin
            ack_cnt <= ack_cnt + AW'(1);
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            state <= IDLE;
            if (last_q) begin
              locked <= 1'b0;
              rr_ptr <= next_ptr;
            end else begin
              locked <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench
// busy model: rises 1 cycle after tx_start, 20 cycles
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic [1:0] grant_id;
  logic       locked;
  logic       err_ack_timeout;
  logic       err_lock_revoked;

  int total = 0;
  int passed = 0;
  int fails = 0;

  logic no_ack = 1'b0;
  int   busy_cnt = 0;

  logic [8:0] rq [N][16];
  int         hd [N];
  int         tl [N];

  logic [7:0] sent_data [$];
  logic [1:0] sent_id [$];
  logic       sent_lock [$];

  logic [7:0] e [4];
  logic [1:0] ei [4];
  int         n;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ      (N),
    .ACK_TIMEOUT  (4),
    .LOCK_TIMEOUT (50)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .req              (bus.slave),
    .tx_data          (tx_data),
    .tx_start         (tx_start),
    .tx_busy          (tx_busy),
    .grant_id         (grant_id),
    .locked           (locked),
    .err_ack_timeout  (err_ack_timeout),
    .err_lock_revoked (err_lock_revoked)
  );

  always #5 clk = ~clk;

  // transmitter model
  always @(posedge clk) begin
    if (tx_start && !no_ack) busy_cnt <= 20;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  // log every byte handed to the transmitter
  always @(posedge clk) begin
    if (tx_start) begin
      sent_data.push_back(tx_data);
      sent_id.push_back(grant_id);
      sent_lock.push_back(locked);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic push(
    input int       i,
    input logic     last,
    input logic [7:0] d
  );
    rq[i][tl[i]] = {last, d};
    tl[i]++;
  endtask

  function automatic logic pending();
    logic p;
    p = 1'b0;
    for (int i = 0; i < N; i++)
      if (hd[i] != tl[i]) p = 1'b1;
    return p;
  endfunction

  task automatic drive();
    logic [N-1:0]   v;
    logic [N-1:0]   l;
    logic [8*N-1:0] d;
    v = '0;
    l = '0;
    d = '0;
    for (int i = 0; i < N; i++) begin
      if (hd[i] != tl[i]) begin
        v = v | (N'(1) << i);
        l = l | (N'(rq[i][hd[i]][8]) << i);
        d = d | ((8*N)'(rq[i][hd[i]][7:0]) << (8 * i));
      end
    end
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = d;
  endtask

  task automatic cyc();
    logic [N-1:0] rdy;
    @(negedge clk);
    rdy = bus.req_ready;
    chk("ready_onehot", 32'($onehot0(rdy)), 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (((rdy >> i) & N'(1)) != '0) hd[i]++;
    drive();
    #1;
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (pending() && k < budget) begin
      cyc();
      k++;
    end
    chk("drain_budget", 32'(pending()), 0);
    repeat (26) cyc();
  endtask

  task automatic wait_start(input int budget);
    int k;
    k = 0;
    while (!tx_start && k < budget) begin
      cyc();
      k++;
    end
    chk("start_seen", 32'(tx_start), 1);
  endtask

  task automatic clear_log();
    sent_data.delete();
    sent_id.delete();
    sent_lock.delete();
  endtask

  initial begin
    drive();
    repeat (3) cyc();

    // reset values
    chk("rst_ready", 32'(bus.req_ready), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_err_ack", 32'(err_ack_timeout), 0);
    chk("rst_err_lock", 32'(err_lock_revoked), 0);
    reset = 1'b0;

    // single byte from req0
    push(0, 1'b1, 8'h41);
    drive();
    #1;
    chk("t1_ready", 32'(bus.req_ready), 32'h1);
    cyc();
    chk("t1_start", 32'(tx_start), 1);
    chk("t1_data", 32'(tx_data), 32'h41);
    chk("t1_ready_off", 32'(bus.req_ready), 0);
    cyc();
    chk("t1_start_off", 32'(tx_start), 0);
    chk("t1_busy", 32'(tx_busy), 1);
    drain(10);
    chk("t1_locked", 32'(locked), 0);
    chk("t1_hold", 32'(tx_data), 32'h41);
    chk("t1_count", 32'(sent_data.size()), 1);

    // four single-byte packets, pointer at 1
    clear_log();
    push(0, 1'b1, 8'h10);
    push(1, 1'b1, 8'h20);
    push(2, 1'b1, 8'h30);
    push(3, 1'b1, 8'h40);
    drive();
    drain(200);
    e = '{8'h20, 8'h30, 8'h40, 8'h10};
    for (int k = 0; k < 4; k++)
      chk("t2a_order", 32'(sent_data[k]), 32'(e[k]));

    // same after reset, pointer at 0
    reset = 1'b1;
    repeat (2) cyc();
    reset = 1'b0;
    clear_log();
    push(0, 1'b1, 8'h10);
    push(1, 1'b1, 8'h20);
    push(2, 1'b1, 8'h30);
    push(3, 1'b1, 8'h40);
    drive();
    drain(200);
    e  = '{8'h10, 8'h20, 8'h30, 8'h40};
    ei = '{2'd0, 2'd1, 2'd2, 2'd3};
    for (int k = 0; k < 4; k++) begin
      chk("t2b_order", 32'(sent_data[k]), 32'(e[k]));
      chk("t2b_id", 32'(sent_id[k]), 32'(ei[k]));
    end

    // 3-byte packet holds off req1
    clear_log();
    push(0, 1'b0, 8'hA0);
    push(0, 1'b0, 8'hA1);
    push(0, 1'b1, 8'hA2);
    push(1, 1'b1, 8'h55);
    drive();
    drain(400);
    e  = '{8'hA0, 8'hA1, 8'hA2, 8'h55};
    ei = '{2'd0, 2'd0, 2'd0, 2'd1};
    for (int k = 0; k < 4; k++) begin
      chk("t3_order", 32'(sent_data[k]), 32'(e[k]));
      chk("t3_id", 32'(sent_id[k]), 32'(ei[k]));
    end
    chk("t3_lock0", 32'(sent_lock[0]), 0);
    chk("t3_lock1", 32'(sent_lock[1]), 1);
    chk("t3_lock2", 32'(sent_lock[2]), 1);
    chk("t3_lock3", 32'(sent_lock[3]), 0);

    // stalled owner loses its lock
    clear_log();
    push(0, 1'b0, 8'hB0);
    drive();
    #1;
    n = 0;
    while (sent_data.size() == 0 && n < 10) begin
      cyc();
      n++;
    end
    push(2, 1'b1, 8'hC2);
    drive();
    repeat (30) cyc();
    chk("t4_locked_mid", 32'(locked), 1);
    chk("t4_err_mid", 32'(err_lock_revoked), 0);
    chk("t4_held_off", 32'(bus.req_ready), 0);
    chk("t4_count_mid", 32'(sent_data.size()), 1);
    drain(300);
    chk("t4_err", 32'(err_lock_revoked), 1);
    chk("t4_unlocked", 32'(locked), 0);
    chk("t4_next", 32'(sent_data[1]), 32'hC2);
    chk("t4_next_id", 32'(sent_id[1]), 2);

    // transmitter never acknowledges
    clear_log();
    no_ack = 1'b1;
    push(3, 1'b1, 8'h77);
    drive();
    wait_start(10);
    cyc();
    no_ack = 1'b0;
    repeat (3) cyc();
    chk("t5_err_early", 32'(err_ack_timeout), 0);
    cyc();
    chk("t5_err", 32'(err_ack_timeout), 1);
    push(1, 1'b1, 8'h99);
    drive();
    drain(100);
    chk("t5_first", 32'(sent_data[0]), 32'h77);
    chk("t5_next", 32'(sent_data[1]), 32'h99);
    chk("t5_sticky", 32'(err_lock_revoked), 1);

    // reset while transmitter is busy
    clear_log();
    push(0, 1'b1, 8'h5A);
    drive();
    wait_start(10);
    repeat (3) cyc();
    reset = 1'b1;
    push(2, 1'b1, 8'h3C);
    drive();
    #1;
    cyc();
    chk("t6_busy", 32'(tx_busy), 1);
    chk("t6_data", 32'(tx_data), 0);
    chk("t6_start", 32'(tx_start), 0);
    chk("t6_grant", 32'(grant_id), 0);
    chk("t6_err_ack", 32'(err_ack_timeout), 0);
    chk("t6_err_lock", 32'(err_lock_revoked), 0);
    chk("t6_ready", 32'(bus.req_ready), 0);
    reset = 1'b0;
    #1;
    n = 0;
    while (tx_busy && n < 40) begin
      chk("t6_no_start", 32'(tx_start), 0);
      chk("t6_no_ready", 32'(bus.req_ready), 0);
      cyc();
      n++;
    end
    chk("t6_idle", 32'(tx_busy), 0);
    chk("t6_grant2", 32'(bus.req_ready), 32'h4);
    drain(50);
    chk("t6_first", 32'(sent_data[0]), 32'h5A);
    chk("t6_after", 32'(sent_data[1]), 32'h3C);
    chk("t6_after_id", 32'(sent_id[1]), 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter among NUM_REQ on-chip requesters (e.g. status reporter, echo path, debug dump). Each requester offers bytes over a valid/ready handshake. Grants are round-robin per packet, and the grant stays locked to one requester until its byte flagged last has been sent. The block drives the data_to_send / tx_start_tick inputs of uart_top and sequences each byte off tx_busy.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ACK_TIMEOUT, 4, max cycles to wait for tx_busy to rise after tx_start before proceeding anyway
LOCK_TIMEOUT, 120000, idle cycles (10 ms at 12 MHz) an owner may stall mid-packet before its lock is revoked

Ports:
clk  in  1  system clock (12 MHz)
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  requester i has a byte available
req_data  in  8*NUM_REQ  byte of requester i at bits [8i+7:8i]
req_last  in  NUM_REQ  byte of requester i ends its packet
req_ready  out  NUM_REQ  one-cycle pulse: byte of requester i accepted this cycle
tx_data  out  8  to uart_top data_to_send
tx_start  out  1  to uart_top tx_start_tick, one-cycle pulse
tx_busy  in  1  from uart_top, high while transmitter is busy
grant_id  out  clog2(NUM_REQ)  requester of the byte currently or last sent
locked  out  1  a packet is in progress; grant is held
err_ack_timeout  out  1  sticky: tx_busy failed to rise within ACK_TIMEOUT
err_lock_revoked  out  1  sticky: a lock was revoked by LOCK_TIMEOUT

Behaviour:
- Clock is clk. Reset is synchronous and active-high on port reset; all state updates on the rising edge of clk.
- Reset values: req_ready=0, tx_data=0x00, tx_start=0, grant_id=0, locked=0, both err flags=0, rr pointer=0, state=IDLE, counters=0.
- IDLE:
  - Requires tx_busy=0 before accepting; otherwise wait.
  - If locked: accept only from grant_id when req_valid[grant_id]=1.
  - If not locked: pick the first valid requester searching from rr pointer upward, wrapping at NUM_REQ.
  - On accept, in the same cycle: req_ready[g]=1 (single-hot), latch tx_data=req_data[g], latch the last bit, grant_id=g, go to START.
- START: tx_start=1 for exactly one cycle, tx_data stable. Go to WAIT_ACK.
- WAIT_ACK:
  - If tx_busy=1, go to WAIT_DONE.
  - Otherwise count. When the count reaches ACK_TIMEOUT, set err_ack_timeout and go to WAIT_DONE.
- WAIT_DONE: when tx_busy=0, go to IDLE.
  - If the latched last=1: locked=0, rr pointer = grant_id+1 mod NUM_REQ.
  - Else: locked=1.
- Latency: accept-to-tx_start is 1 cycle. Minimum byte period is accept, start, at least 1 ack cycle, and the busy duration.
- tx_data holds its value until the next accept.
- Lock timeout: while locked in IDLE with req_valid[grant_id]=0, count idle cycles; any accept clears the count. At LOCK_TIMEOUT: locked=0, rr pointer = grant_id+1, set err_lock_revoked.
- Single-byte packet (last=1 on the first byte): the lock is never asserted.
- Simultaneous requests: only one req_ready per cycle. Other requesters must hold valid and data until their own ready pulse.
- req_valid deasserted without ready is permitted: the byte is withdrawn and nothing is sent.
- Reset mid-transfer: FSM returns to IDLE and tx_start drops. The uart_tx byte in flight completes because IDLE waits for tx_busy=0 before the next grant.
- tx_busy high in IDLE (e.g. after reset): no accept until it falls.
- Err flags clear only on reset.

Decomposition:
- Shared header uart_arb_defs.vh: state encodings (IDLE, START, WAIT_ACK, WAIT_DONE) and a clog2 function/macro.
- One sub-module, uart_rr_picker: combinational round-robin first-valid search taking (req_valid, rr_ptr) and giving (found, index). It is instantiated once and reusable by other arbiters.

Test Plan:
Bench transmitter model: tx_busy rises 1 cycle after tx_start and stays high 20 cycles.
- Reset, then req_valid=0001, data 0x41, last=1 -> req_ready=0001 for 1 cycle; tx_start 1 cycle later with tx_data=0x41; locked stays 0; rr pointer=1.
- All four valid, each with a single-byte packet (0x10,0x20,0x30,0x40, last=1) -> bytes sent in order 0x10,0x20,0x30,0x40. Repeat from rr=1 -> order 0x20,0x30,0x40,0x10.
- Req0 sends a 3-byte packet 0xA0,0xA1,0xA2 (last on 0xA2) while req1 is valid throughout -> req1 receives no ready until 0xA2 completes; locked=1 during the packet.
- Req0 sends 0xB0 with last=0, then drops valid -> after LOCK_TIMEOUT (shortened to 50 in bench) locked=0, err_lock_revoked=1, pending req2 granted next.
- Model holds tx_busy low after tx_start -> err_ack_timeout=1 after ACK_TIMEOUT cycles; FSM returns to IDLE and serves the next request.
- Assert reset during WAIT_DONE with the model still busy -> outputs at reset values next cycle; no tx_start until tx_busy falls.
